// File: rtl/ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the control pipeline.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  typedef struct packed {
    logic       valid;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       memto_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       pc_add;
    logic [1:0] alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic memto_reg;
    logic reg_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic valid;
    logic memto_reg;
    logic reg_write;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_CTRL_ZERO  = '0;
  localparam mem_ctrl_t MEM_CTRL_ZERO = '0;
  localparam wb_ctrl_t  WB_CTRL_ZERO  = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ID-stage main decoder: opcode to EX control bundle, plus source-register usage.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned EN_JUMP = 1
) (
  input  logic       valid,
  input  logic [6:0] opcode,
  output ex_ctrl_t   ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  always_comb begin
    ctrl = EX_CTRL_ZERO;
    if (valid) begin
      case (opcode)
        OP_R: begin
          ctrl.valid     = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        OP_I: begin
          ctrl.valid     = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        OP_LOAD: begin
          ctrl.valid     = 1'b1;
          ctrl.mem_read  = 1'b1;
          ctrl.memto_reg = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_STORE: begin
          ctrl.valid     = 1'b1;
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_BRANCH: begin
          ctrl.valid  = 1'b1;
          ctrl.branch = 1'b1;
          ctrl.alu_op = ALUOP_BR;
        end
        OP_JAL: if (EN_JUMP != 0) begin
          ctrl.valid     = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_JALR: if (EN_JUMP != 0) begin
          ctrl.valid     = 1'b1;
          ctrl.jump      = 1'b1;
          ctrl.jalr      = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        OP_LUI: if (EN_JUMP != 0) begin
          ctrl.valid     = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_PASSB;
        end
        OP_AUIPC: if (EN_JUMP != 0) begin
          ctrl.valid     = 1'b1;
          ctrl.pc_add    = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = ALUOP_ADD;
        end
        default: ;
      endcase
    end
  end

  assign uses_rs1 = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: decodes ID, detects load-use hazards and carries control
// through the ID/EX, EX/MEM and MEM/WB stage registers.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned ALUOP_W   = 2,
  parameter int unsigned EN_JUMP   = 1,
  parameter int unsigned EN_HAZARD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_AW-1:0]     id_rs1,
  input  logic [REG_AW-1:0]     id_rs2,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic                  ex_flush,
  output logic                  hazard_stall,
  output logic [10+ALUOP_W-1:0] ex_ctrl,
  output logic [REG_AW-1:0]     ex_rd,
  output logic [4:0]            mem_ctrl,
  output logic [REG_AW-1:0]     mem_rd,
  output logic [2:0]            wb_ctrl,
  output logic [REG_AW-1:0]     wb_rd
);

  ex_ctrl_t            dec_ctrl;
  logic                uses_rs1;
  logic                uses_rs2;
  ex_ctrl_t            ex_q;
  mem_ctrl_t           mem_q;
  wb_ctrl_t            wb_q;
  logic [REG_AW-1:0]   ex_rd_q;
  logic [REG_AW-1:0]   mem_rd_q;
  logic [REG_AW-1:0]   wb_rd_q;
  logic                rs1_hit;
  logic                rs2_hit;
  logic                bubble;

  ctrl_decode #(
    .EN_JUMP (EN_JUMP)
  ) u_decode (
    .valid    (id_valid),
    .opcode   (id_opcode),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Only a valid load in EX can create a load-use dependency; x0 never does.
  always_comb begin
    rs1_hit      = uses_rs1 && (ex_rd_q == id_rs1);
    rs2_hit      = uses_rs2 && (ex_rd_q == id_rs2);
    hazard_stall = 1'b0;
    if (EN_HAZARD != 0)
      hazard_stall = id_valid && ex_q.valid && ex_q.mem_read &&
                     (ex_rd_q != '0) && (rs1_hit || rs2_hit);
  end

  assign bubble = ex_flush || hazard_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= EX_CTRL_ZERO;
      ex_rd_q <= '0;
    end else if (bubble) begin
      ex_q    <= EX_CTRL_ZERO;
      ex_rd_q <= '0;
    end else begin
      ex_q    <= dec_ctrl;
      ex_rd_q <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= MEM_CTRL_ZERO;
      mem_rd_q <= '0;
      wb_q     <= WB_CTRL_ZERO;
      wb_rd_q  <= '0;
    end else begin
      mem_q    <= '{valid:     ex_q.valid,
                    mem_read:  ex_q.mem_read,
                    mem_write: ex_q.mem_write,
                    memto_reg: ex_q.memto_reg,
                    reg_write: ex_q.reg_write};
      mem_rd_q <= ex_rd_q;
      wb_q     <= '{valid:     mem_q.valid,
                    memto_reg: mem_q.memto_reg,
                    reg_write: mem_q.reg_write};
      wb_rd_q  <= mem_rd_q;
    end
  end

  assign ex_ctrl  = {ex_q[$bits(ex_ctrl_t)-1:2], ALUOP_W'(ex_q.alu_op)};
  assign ex_rd    = ex_rd_q;
  assign mem_ctrl = mem_q;
  assign mem_rd   = mem_rd_q;
  assign wb_ctrl  = wb_q;
  assign wb_rd    = wb_rd_q;

endmodule
